gcd_dispatch: RTL and testbench

Front-end stage for the binary GCD core. Accepts operand pairs over a valid/ready stream, buffers them in a small FIFO, and drives the core's start/A_in/B_in interface one job at a time. It captures the core's one-cycle result_valid pulse and presents each result on a valid/ready output stream, in order. Zero operands are resolved locally, because the core never terminates on a zero input.

---
 rtl/gcd_dispatch_if.sv | 34 +++
 rtl/gcd_dispatch.sv | 140 ++++++++++++++
 tb/tb_gcd_dispatch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_dispatch_if.sv
// Stream and core-side signal bundle for gcd_dispatch.
// slave is the dispatcher's view; master is the driving/observing environment.
interface gcd_dispatch_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [W-1:0]             in_a;
    logic [W-1:0]             in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [W-1:0]             out_gcd;
    logic                     out_err;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     core_rst;
    logic                     core_start;
    logic [W-1:0]             core_a;
    logic [W-1:0]             core_b;
    logic [W-1:0]             core_result;
    logic                     core_valid;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, core_result, core_valid,
        output in_ready, out_valid, out_gcd, out_err, fifo_level,
               core_rst, core_start, core_a, core_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, core_result, core_valid,
        input  in_ready, out_valid, out_gcd, out_err, fifo_level,
               core_rst, core_start, core_a, core_b
    );
endinterface

// File: rtl/gcd_dispatch.sv
// Operand FIFO plus one-job-at-a-time sequencer in front of the binary GCD core.
// Optional macro GCD_DISPATCH_TIMEOUT_EN adds a WAIT watchdog that resets the core.
module gcd_dispatch #(
    parameter int unsigned W           = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 4 * W + 8
) (
    input logic           clk,
    input logic           rst_n,
    gcd_dispatch_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

    state_e          r_state, w_state_nxt;
    logic [W-1:0]    r_mem_a [DEPTH];
    logic [W-1:0]    r_mem_b [DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [LW-1:0]   r_count;
    logic [W-1:0]    r_op_a, r_op_b, r_res;
    logic            r_core_rst;
    logic            w_full, w_empty, w_push, w_pop, w_timeout;
    logic [W-1:0]    w_head_a, w_head_b;
    logic            w_core_start, w_out_valid;

    assign w_full   = (r_count == LW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_head_a = r_mem_a[r_rptr];
    assign w_head_b = r_mem_b[r_rptr];
    // in_ready excludes pop in the same cycle, so a full FIFO never pushes through.
    assign w_push   = bus.in_valid && !w_full && !r_core_rst;
    assign w_pop    = (r_state == StIdle) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr] <= bus.in_a;
            r_mem_b[r_wptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GCD_DISPATCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_timeout = (r_state == StWait) && !bus.core_valid &&
                       (r_tmo == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= (r_state == StWait) ? r_tmo + TW'(1) : '0;
            if (w_pop)          r_err <= 1'b0;
            else if (w_timeout) r_err <= 1'b1;
        end
    end

    assign bus.out_err = r_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC == 0);
    assign w_timeout    = 1'b0;
    assign bus.out_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_state_nxt = (w_head_a == '0 || w_head_b == '0) ? StOut : StIssue;
                end
            end
            StIssue: w_state_nxt = StWait;
            StWait:  if (bus.core_valid || w_timeout) w_state_nxt = StOut;
            StOut:   if (bus.out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_core_start = (r_state == StIssue);
        w_out_valid  = (r_state == StOut);
    end

    // A zero operand resolves as a|b; non-zero jobs overwrite r_res from the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_res      <= '0;
            r_core_rst <= 1'b1;
        end else begin
            r_core_rst <= w_timeout;
            if (w_pop) begin
                r_op_a <= w_head_a;
                r_op_b <= w_head_b;
                r_res  <= w_head_a | w_head_b;
            end else if (r_state == StWait && bus.core_valid) begin
                r_res  <= bus.core_result;
            end else if (w_timeout) begin
                r_res  <= '0;
            end
        end
    end

    assign bus.in_ready   = !w_full && !r_core_rst;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_gcd    = r_res;
    assign bus.fifo_level = r_count;
    assign bus.core_rst   = r_core_rst;
    assign bus.core_start = w_core_start;
    assign bus.core_a     = r_op_a;
    assign bus.core_b     = r_op_b;
endmodule

// File: tb/tb_gcd_dispatch.sv
// Bench for gcd_dispatch: behavioural GCD core, driver, and in-order result scoreboard.
// Define GCD_DISPATCH_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_gcd_dispatch;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gcd_dispatch_if #(.W(16), .DEPTH(4)) bus ();

    gcd_dispatch #(.W(16), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_starts = 0;
    logic [16:0] sb[$];     // {err, gcd}
    logic        mute;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: latches operands on start, answers after a few cycles.
    logic [15:0] m_x, m_y;
    int          m_cnt;
    logic        m_busy;
    always @(posedge clk) begin
        bus.core_valid <= 1'b0;
        if (bus.core_rst) begin
            m_busy <= 1'b0;
        end else if (bus.core_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 3 + int'(bus.core_a % 4);
            m_x    <= bus.core_a;
            m_y    <= bus.core_b;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                if (!mute) begin
                    bus.core_valid  <= 1'b1;
                    bus.core_result <= ref_gcd(m_x, m_y);
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out", 32'(bus.out_gcd), 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                check_eq("out_gcd", 32'(bus.out_gcd), 32'(e[15:0]));
                check_eq("out_err", 32'(bus.out_err), 32'(e[16]));
            end
        end
        if (bus.core_start) n_starts++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        else sb.push_back(exp);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
            tick();
            n++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_start();
        int n = 0;
        while (!bus.core_start && n < 100) begin
            tick();
            n++;
        end
        check_eq("core_start_seen", 32'(bus.core_start), 32'd1);
    endtask

    initial begin
        int          s0;
        int          n;
        logic [15:0] held;

        rst_n          = 1'b0;
        mute           = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b0;
        repeat (3) tick();

        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_level", 32'(bus.fifo_level), 32'd0);
        check_eq("rst_core_rst", 32'(bus.core_rst), 32'd1);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_core_start", 32'(bus.core_start), 32'd0);
        check_eq("rst_out_gcd", 32'(bus.out_gcd), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("core_rst_hold", 32'(bus.core_rst), 32'd1);
        tick();
        check_eq("core_rst_clear", 32'(bus.core_rst), 32'd0);
        check_eq("in_ready_up", 32'(bus.in_ready), 32'd1);

        // Single core job
        bus.out_ready = 1'b1;
        s0 = n_starts;
        push_pair(16'd48, 16'd18, {1'b0, 16'd6});
        drain();
        check_eq("one_start", 32'(n_starts - s0), 32'd1);
        check_eq("level_empty", 32'(bus.fifo_level), 32'd0);

        // Zero bypass: no core involvement, out_valid one cycle after the pop
        s0 = n_starts;
        push_pair(16'd0, 16'd35, {1'b0, 16'd35});
        check_eq("bypass_pop_cycle", 32'(bus.out_valid), 32'd0);
        tick();
        check_eq("bypass_out_valid", 32'(bus.out_valid), 32'd1);
        push_pair(16'd0, 16'd0, {1'b0, 16'd0});
        drain();
        check_eq("bypass_no_start", 32'(n_starts - s0), 32'd0);

        // Backpressure fills the FIFO
        bus.out_ready = 1'b0;
        push_pair(16'd12, 16'd8, {1'b0, 16'd4});
        push_pair(16'd17, 16'd5, {1'b0, 16'd1});
        check_eq("level_push_pop", 32'(bus.fifo_level), 32'd1);
        push_pair(16'd64, 16'd64, {1'b0, 16'd64});
        push_pair(16'd1024, 16'd6, {1'b0, 16'd2});
        push_pair(16'd65535, 16'd255, {1'b0, 16'd255});
        check_eq("full_level", 32'(bus.fifo_level), 32'd4);
        check_eq("full_in_ready", 32'(bus.in_ready), 32'd0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("hold_first", 32'(bus.out_gcd), 32'd4);
        held = bus.out_gcd;
        s0   = n_starts;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold_gcd", 32'(bus.out_gcd), 32'(held));
        end
        check_eq("hold_no_start", 32'(n_starts - s0), 32'd0);
        check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        drain();

        // Reset in WAIT discards the job
        push_pair(16'd1000, 16'd10, {1'b0, 16'd10});
        wait_start();
        tick();
        sb.delete();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_level", 32'(bus.fifo_level), 32'd0);
        check_eq("midrst_core_rst", 32'(bus.core_rst), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        push_pair(16'd21, 16'd14, {1'b0, 16'd7});
        drain();

`ifdef GCD_DISPATCH_TIMEOUT_EN
        mute = 1'b1;
        push_pair(16'd9, 16'd6, {1'b1, 16'd0});
        wait_start();
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq("tmo_latency", 32'(n), 32'd73);
        check_eq("tmo_core_rst", 32'(bus.core_rst), 32'd1);
        check_eq("tmo_err", 32'(bus.out_err), 32'd1);
        check_eq("tmo_gcd", 32'(bus.out_gcd), 32'd0);
        tick();
        check_eq("tmo_core_rst_pulse", 32'(bus.core_rst), 32'd0);
        mute = 1'b0;
        push_pair(16'd0, 16'd5, {1'b0, 16'd5});
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
